ks_note_sequencer: RTL and testbench

- Control-side driver for the Karplus-Strong string voice; it generates the voice's pluck strobe and period word.
- Holds a small step table of note/rest entries, written by the host.
- Plays the table at a programmable tempo and fires one timed pluck pulse per note step.
- Single-shot or looping playback; sits between the host register interface and the string's pluck_i/period_i inputs.

---
 rtl/ks_note_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_ks_note_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ks_note_sequencer.sv
// Step-table note sequencer that drives the Karplus-Strong voice's pluck strobe and period word.
// Optional swing timing on odd steps is compiled in when KS_SEQ_SWING_EN is defined.
module ks_note_sequencer #(
    parameter int STEPS       = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int TEMPO_WIDTH = 16,
    parameter int PLUCK_HIGH  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       run_i,
    input  logic                       loop_i,
    input  logic [$clog2(STEPS):0]     len_i,
    input  logic [TEMPO_WIDTH-1:0]     tempo_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(STEPS)-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH:0]        wr_data_i,
`ifdef KS_SEQ_SWING_EN
    input  logic                       swing_i,
`endif
    output logic                       pluck_o,
    output logic [DATA_WIDTH-1:0]      period_o,
    output logic [$clog2(STEPS)-1:0]   step_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int AW = $clog2(STEPS);
    localparam int LW = AW + 1;
    localparam int TW = TEMPO_WIDTH + 1;
    localparam int PW = $clog2(PLUCK_HIGH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_PLUCK = 2'b10,
        ST_WAIT  = 2'b11
    } state_t;

    // The step must outlast the pluck pulse plus the LOAD cycle and one WAIT cycle.
    function automatic logic [TW-1:0] step_dur_f(input logic [TEMPO_WIDTH-1:0] tempo);
        logic [TW-1:0] t;
        t = {1'b0, tempo};
        if (t < TW'(PLUCK_HIGH + 2)) begin
            t = TW'(PLUCK_HIGH + 2);
        end else begin
            t = t;
        end
        return t;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] period_clamp_f(input logic [DATA_WIDTH-1:0] p);
        logic [DATA_WIDTH-1:0] q;
        if (p < DATA_WIDTH'(2)) begin
            q = DATA_WIDTH'(2);
        end else begin
            q = p;
        end
        return q;
    endfunction

    state_t                  state_r, state_s;
    logic [DATA_WIDTH:0]     step_tbl_r [STEPS];
    logic [AW-1:0]           step_r, step_s;
    logic [TW-1:0]           timer_r, timer_s;
    logic [PW-1:0]           pcnt_r, pcnt_s;
    logic                    pluck_r, pluck_s;
    logic [DATA_WIDTH-1:0]   period_r, period_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic [DATA_WIDTH:0]     entry_s;
    logic [TW-1:0]           base_dur_s, dur_s;
    logic [LW-1:0]           eff_len_s;
    logic                    last_s;

    // Host table writes; a write landing in a LOAD cycle is seen only on the next visit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STEPS; i++) begin
                step_tbl_r[i] <= {(DATA_WIDTH + 1){1'b0}};
            end
        end else if (wr_en_i) begin
            step_tbl_r[wr_addr_i] <= wr_data_i;
        end
    end

    // Next-state and next-output logic for the playback FSM.
    always_comb begin
        entry_s    = step_tbl_r[step_r];
        base_dur_s = step_dur_f(tempo_i);
`ifdef KS_SEQ_SWING_EN
        if (swing_i && step_r[0]) begin
            dur_s = base_dur_s + (base_dur_s >> 2);
        end else begin
            dur_s = base_dur_s;
        end
`else
        dur_s = base_dur_s;
`endif
        if ((len_i == {LW{1'b0}}) || (len_i > LW'(STEPS))) begin
            eff_len_s = LW'(STEPS);
        end else begin
            eff_len_s = len_i;
        end
        last_s = ({1'b0, step_r} >= (eff_len_s - LW'(1)));

        state_s  = state_r;
        step_s   = step_r;
        timer_s  = (timer_r != {TW{1'b0}}) ? (timer_r - TW'(1)) : timer_r;
        pcnt_s   = pcnt_r;
        pluck_s  = pluck_r;
        period_s = period_r;
        done_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                pluck_s = 1'b0;
                if (run_i) begin
                    state_s = ST_LOAD;
                    step_s  = {AW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!run_i) begin
                    state_s = ST_IDLE;
                    pluck_s = 1'b0;
                end else begin
                    // Timer counts the D-1 cycles after LOAD; the step ends when it reads zero.
                    timer_s = dur_s - TW'(2);
                    if (entry_s[DATA_WIDTH]) begin
                        period_s = period_clamp_f(entry_s[DATA_WIDTH-1:0]);
                        pcnt_s   = PW'(PLUCK_HIGH);
                        pluck_s  = 1'b1;
                        state_s  = ST_PLUCK;
                    end else begin
                        pluck_s  = 1'b0;
                        state_s  = ST_WAIT;
                    end
                end
            end
            ST_PLUCK: begin
                if (!run_i) begin
                    state_s = ST_IDLE;
                    pluck_s = 1'b0;
                end else if (pcnt_r <= PW'(1)) begin
                    pcnt_s  = {PW{1'b0}};
                    pluck_s = 1'b0;
                    state_s = ST_WAIT;
                end else begin
                    pcnt_s  = pcnt_r - PW'(1);
                end
            end
            ST_WAIT: begin
                pluck_s = 1'b0;
                if (!run_i) begin
                    state_s = ST_IDLE;
                end else if (timer_r == {TW{1'b0}}) begin
                    if (!last_s) begin
                        step_s  = step_r + AW'(1);
                        state_s = ST_LOAD;
                    end else if (loop_i) begin
                        step_s  = {AW{1'b0}};
                        state_s = ST_LOAD;
                    end else begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                pluck_s = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and registered-output update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            step_r   <= {AW{1'b0}};
            timer_r  <= {TW{1'b0}};
            pcnt_r   <= {PW{1'b0}};
            pluck_r  <= 1'b0;
            period_r <= {DATA_WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            step_r   <= step_s;
            timer_r  <= timer_s;
            pcnt_r   <= pcnt_s;
            pluck_r  <= pluck_s;
            period_r <= period_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign pluck_o  = pluck_r;
    assign period_o = period_r;
    assign step_o   = step_r;
    assign busy_o   = busy_r;
    assign done_o   = done_r;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Self-checking bench for ks_note_sequencer: directed scenarios plus randomized tables
// compared against a cycle-timeline model derived from step duration arithmetic.
module tb_ks_note_sequencer;

    localparam int STEPS = 16;
    localparam int PH    = 8;

    logic        clk_i     = 1'b0;
    logic        rst_i     = 1'b1;
    logic        run_i     = 1'b0;
    logic        loop_i    = 1'b0;
    logic [4:0]  len_i     = 5'd0;
    logic [15:0] tempo_i   = 16'd0;
    logic        wr_en_i   = 1'b0;
    logic [3:0]  wr_addr_i = 4'd0;
    logic [8:0]  wr_data_i = 9'd0;
    logic        pluck_o;
    logic [7:0]  period_o;
    logic [3:0]  step_o;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_errors = 0;

    bit m_note [STEPS];
    int m_per  [STEPS];
    int m_period;
    int m_step;

    always #5 clk_i = ~clk_i;

    ks_note_sequencer dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .run_i     (run_i),
        .loop_i    (loop_i),
        .len_i     (len_i),
        .tempo_i   (tempo_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
`ifdef KS_SEQ_SWING_EN
        .swing_i   (1'b0),
`endif
        .pluck_o   (pluck_o),
        .period_o  (period_o),
        .step_o    (step_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic tbl_write(input int a, input bit note, input int p);
        wr_en_i   = 1'b1;
        wr_addr_i = 4'(a);
        wr_data_i = {note, 8'(p)};
        tick();
        wr_en_i   = 1'b0;
        m_note[a] = note;
        m_per[a]  = p;
    endtask

    function automatic int clamp2(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    // Plays from step 0; every cycle is predicted from t = cycles since LOAD of step 0.
    task automatic run_seq(input int len, input int tempo, input bit lp, input int max_cyc, input bit hold_done);
        int n, d, t, k, s, off;
        bit e_pluck, e_busy, e_done, finished;
        n = (len == 0 || len > STEPS) ? STEPS : len;
        d = (tempo < PH + 2) ? PH + 2 : tempo;
        len_i   = 5'(len);
        tempo_i = 16'(tempo);
        loop_i  = lp;
        run_i   = 1'b1;
        finished = 1'b0;
        for (int j = 1; j <= max_cyc && !finished; j++) begin
            tick();
            t = j - 1;
            if (!lp && t >= n * d) begin
                e_done = 1'b1; e_busy = 1'b0; e_pluck = 1'b0;
                m_step = n - 1;
                finished = 1'b1;
            end else begin
                k = t / d;
                s = lp ? (k % n) : k;
                off = t % d;
                m_step = s;
                e_busy = 1'b1; e_done = 1'b0;
                if (off == 1 && m_note[s]) m_period = clamp2(m_per[s]);
                e_pluck = m_note[s] && off >= 1 && off <= PH;
            end
            chk("pluck", pluck_o, e_pluck);
            chk("busy", busy_o, e_busy);
            chk("done", done_o, e_done);
            chk("step", step_o, m_step);
            chk("period", period_o, m_period);
            if (finished && !hold_done) run_i = 1'b0;
        end
        if (finished && hold_done) begin
            tick();
            chk("restart_busy", busy_o, 1);
            chk("restart_step", step_o, 0);
            chk("restart_done", done_o, 0);
            m_step = 0;
        end
        run_i = 1'b0;
        tick();
        chk("stop_busy", busy_o, 0);
        chk("stop_pluck", pluck_o, 0);
        chk("stop_done", done_o, 0);
        chk("stop_step", step_o, m_step);
        chk("stop_period", period_o, m_period);
    endtask

    initial begin
        for (int i = 0; i < STEPS; i++) begin
            m_note[i] = 1'b0;
            m_per[i]  = 0;
        end
        m_period = 0;
        m_step   = 0;

        // Reset held three cycles.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_pluck", pluck_o, 0);
        chk("rst_period", period_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_step", step_o, 0);
        rst_i = 1'b0;
        tick();

        // All-zero table: two rest steps, no pluck.
        run_seq(2, 12, 1'b0, 100, 1'b0);

        // Two notes single-shot at tempo 1000.
        tbl_write(0, 1'b1, 100);
        tbl_write(1, 1'b1, 50);
        run_seq(2, 1000, 1'b0, 2100, 1'b0);

        // Rest keeps prior period; note/1 clamps to 2.
        tbl_write(1, 1'b0, 33);
        tbl_write(2, 1'b1, 1);
        run_seq(3, 20, 1'b0, 100, 1'b0);

        // Looping with tempo below the minimum step length.
        run_seq(3, 3, 1'b1, 65, 1'b0);

        // Abort in the fourth pluck cycle, then replay from step 0.
        run_seq(1, 1000, 1'b0, 5, 1'b0);
        run_seq(1, 12, 1'b0, 100, 1'b0);

        // run_i held through done restarts playback.
        run_seq(2, 10, 1'b0, 100, 1'b1);

        // Write collision with the LOAD of step 0.
        len_i = 5'd1; tempo_i = 16'd10; loop_i = 1'b1; run_i = 1'b1;
        tick();
        chk("coll_load_step", step_o, 0);
        chk("coll_load_busy", busy_o, 1);
        wr_en_i = 1'b1; wr_addr_i = 4'd0; wr_data_i = {1'b1, 8'd77};
        tick();
        wr_en_i = 1'b0;
        chk("coll_first_pluck", pluck_o, 1);
        chk("coll_first_period", period_o, 100);
        for (int j = 3; j <= 12; j++) begin
            tick();
            if (j == 11) chk("coll_reload_pluck", pluck_o, 0);
            if (j == 12) chk("coll_second_pluck", pluck_o, 1);
            if (j == 12) chk("coll_second_period", period_o, 77);
        end
        run_i = 1'b0;
        tick();
        chk("coll_stop_busy", busy_o, 0);
        m_per[0] = 77;
        m_period = 77;
        m_step   = 0;

        // Randomized tables and playback settings.
        for (int it = 0; it < 6; it++) begin
            int len_r, tempo_r, cyc_r;
            bit lp_r, hold_r;
            for (int a = 0; a < STEPS; a++) begin
                tbl_write(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            end
            len_r   = int'($urandom_range(0, 20));
            tempo_r = int'($urandom_range(0, 40));
            lp_r    = 1'($urandom_range(0, 1));
            hold_r  = 1'($urandom_range(0, 1));
            cyc_r   = lp_r ? int'($urandom_range(30, 200)) : 700;
            run_seq(len_r, tempo_r, lp_r, cyc_r, hold_r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
